card_board_loader: RTL and testbench
====================================

Name: card_board_loader

Overview:
- Writer side of the 16-entry card memory. The VGA display path reads that memory on port A; this block writes it on port B.
- On each new game it builds a deck of 8 value pairs and shuffles it with a seeded 8-bit LFSR (Fisher-Yates).
- It then writes all 16 face-down card words into the memory, one word per cycle.
- Sits beside gameplay_sm. The top level muxes this block's WriteEnable/DataLoc/DataOut onto port B while Busy is high.

Parameters:
- MAX_RETRY, 15: rejected LFSR draws allowed per Fisher-Yates step before the step is forced to "no swap".
- SEED_ZERO_SUB, 8'h01: seed value substituted when Seed==0, because an all-zero LFSR locks up.

Ports:
- Clk  in  1  system clock (same 25 MHz clk as VGA and gameplay_sm).
- Reset  in  1  one clock; reset is asynchronous and active-low.
- Start  in  1  single-cycle request to load a new board; sampled only in IDLE.
- Seed  in  8  randomisation seed (switches); sampled in the cycle Start is accepted.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the last word has been written.
- WriteEnable  out  1  port-B write strobe.
- DataLoc  out  4  port-B address (card 0..15, row-major).
- DataOut  out  6  port-B data: bit5 removed, bit4 face-down, bits3:0 value.

Behaviour:
- Reset (async, Reset==0):
  - state=IDLE; Busy=0, Done=0, WriteEnable=0, DataLoc=0, DataOut=0.
  - LFSR=SEED_ZERO_SUB; deck contents don't-care.
- States, one-hot: IDLE, LOAD, SHUFFLE, WRITE, DONE.
- IDLE:
  - Start==1 -> LOAD next cycle.
  - Same edge: LFSR <= (Seed==0 ? SEED_ZERO_SUB : Seed).
- LOAD (1 cycle):
  - deck[k] <= k>>1 for k=0..15, i.e. values 0,0,1,1,...,7,7.
  - i <= 15, retry <= 0.
  - -> SHUFFLE.
- SHUFFLE:
  - Each cycle: j = LFSR[3:0]; LFSR <= {LFSR[6:0], LFSR[7]^LFSR[5]^LFSR[4]^LFSR[3]}.
  - Case j <= i: swap deck[i] and deck[j] (j==i is a legal no-op); i <= i-1; retry <= 0.
  - Case j > i and retry < MAX_RETRY: retry <= retry+1; i unchanged.
  - Case j > i and retry == MAX_RETRY: no swap; i <= i-1; retry <= 0.
  - The step that completes with i==1 goes -> WRITE with k=0.
  - Latency is bounded: at most 15*(MAX_RETRY+1) cycles.
- WRITE (exactly 16 consecutive cycles):
  - WriteEnable=1, DataLoc=k, DataOut={1'b0,1'b1,deck[k]}, registered outputs.
  - k increments 0..15, no gaps.
  - After k==15 -> DONE.
- DONE (1 cycle): Done=1, WriteEnable=0 -> IDLE.
- Output rule: WriteEnable is 0 in every state other than WRITE; DataLoc/DataOut hold their last value when idle.
- Start while Busy: ignored; no restart, no queueing.
- Seed changes while Busy: ignored, because it is latched only at Start.
- Reset mid-operation: immediate abort to the reset values. Memory is left partially written; the next Start rewrites all 16 entries.
- Determinism: identical Seed yields an identical board. Seed 0 and Seed SEED_ZERO_SUB yield identical boards.
- Invariant: after Done, each value 0..7 appears in exactly two locations, all with bit5=0 and bit4=1.

Decomposition:
- Shared package card_pkg:
  - Card word field positions: CARD_REMOVED_BIT=5, CARD_FACEDOWN_BIT=4, CARD_VALUE_MSB=3.
  - NUM_CARDS=16, NUM_PAIRS=8.
  - State encodings.
  - These constants are reused by gameplay_sm and the display mux logic.
- One sub-module: lfsr8.
  - Ports: Clk, Reset, load, load_val[7:0], step, q[7:0].
  - Taps 8,6,5,4; seed-zero substitution happens in the parent.

Test Plan:
- Reset check: assert Reset=0 mid-sim -> Busy=0, Done=0, WriteEnable=0, DataLoc=0, DataOut=0 asynchronously, before the next Clk edge.
- Full load, Seed=8'hA5: pulse Start.
  - Busy rises 1 cycle later.
  - Exactly 16 consecutive WriteEnable cycles with DataLoc 0..15 in order.
  - Done pulses exactly once, 1 cycle after DataLoc=15.
  - Captured values form the multiset {0,0,1,1,...,7,7}; all words have bits5:4=2'b01.
- Determinism: run Seed=8'h3C twice -> identical 16-word images. Seed=8'h00 vs Seed=8'h01 -> identical images. Seed=8'h3C vs 8'hC3 -> images differ.
- Start while Busy: pulse Start again during SHUFFLE and during WRITE, with Seed changed -> no restart, and the image matches the original seed's image.
- Reset mid-WRITE: assert Reset at k==7 -> WriteEnable=0 immediately. Then Start with Seed=8'h5A -> full 16-word rewrite matching a clean Seed=8'h5A run.
- Bounded latency: over all 256 seeds, Start-to-Done cycles <= 1+1+15*(MAX_RETRY+1)+16+1, and the multiset invariant holds for every seed.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card-memory constants, word layout and loader state encoding.
// Reused by the board loader, gameplay_sm and the display mux logic.
package card_pkg;

  localparam int unsigned NUM_CARDS         = 16;
  localparam int unsigned NUM_PAIRS         = 8;
  localparam int unsigned CARD_REMOVED_BIT  = 5;
  localparam int unsigned CARD_FACEDOWN_BIT = 4;
  localparam int unsigned CARD_VALUE_MSB    = 3;
  localparam int unsigned CARD_W            = 6;
  localparam int unsigned VALUE_W           = CARD_VALUE_MSB + 1;
  localparam int unsigned LOC_W             = 4;
  localparam int unsigned SEED_W            = 8;

  localparam int unsigned     DEF_MAX_RETRY     = 15;
  localparam logic [SEED_W-1:0] DEF_SEED_ZERO_SUB = 8'h01;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_LOAD    = 5'b00010,
    ST_SHUFFLE = 5'b00100,
    ST_WRITE   = 5'b01000,
    ST_DONE    = 5'b10000
  } loader_state_e;

  typedef struct packed {
    logic               removed;
    logic               face_down;
    logic [VALUE_W-1:0] value;
  } card_word_t;

  function automatic card_word_t face_down_card(input logic [VALUE_W-1:0] v);
    card_word_t w;
    w.removed   = 1'b0;
    w.face_down = 1'b1;
    w.value     = v;
    return w;
  endfunction

endpackage

// File: rtl/card_board_loader_if.sv
// Control and port-B write bus of the board loader.
// master: the requester (gameplay side); slave: the loader itself.
interface card_board_loader_if;
  import card_pkg::*;

  logic                    Start;
  logic [SEED_W-1:0]       Seed;
  logic                    Busy;
  logic                    Done;
  logic                    WriteEnable;
  logic [LOC_W-1:0]        DataLoc;
  card_word_t              DataOut;

  modport master (
    output Start, Seed,
    input  Busy, Done, WriteEnable, DataLoc, DataOut
  );

  modport slave (
    input  Start, Seed,
    output Busy, Done, WriteEnable, DataLoc, DataOut
  );

endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4. Load has priority over step.
// Seed-zero substitution is the parent's job; never load zero.
module lfsr8 #(
  parameter logic [7:0] RESET_VAL = 8'h01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/card_board_loader.sv
// Builds a deck of value pairs, Fisher-Yates shuffles it from a seeded LFSR,
// then streams all 16 face-down card words onto memory port B.
module card_board_loader
  import card_pkg::*;
#(
  parameter int unsigned       MAX_RETRY     = DEF_MAX_RETRY,
  parameter logic [SEED_W-1:0] SEED_ZERO_SUB = DEF_SEED_ZERO_SUB
) (
  input  logic                Clk,
  input  logic                Reset,
  card_board_loader_if.slave  bus
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  loader_state_e       state;
  logic                busy_q;
  logic                done_q;
  logic                we_q;
  logic [LOC_W-1:0]    loc_q;
  card_word_t          data_q;

  logic [LOC_W-1:0]    idx;
  logic [RETRY_W-1:0]  retry;
  logic [VALUE_W-1:0]  deck [NUM_CARDS];

  logic [SEED_W-1:0]   lfsr_q;
  logic                lfsr_load_c;
  logic                lfsr_step_c;
  logic [SEED_W-1:0]   lfsr_seed_c;
  logic [LOC_W-1:0]    draw_c;
  logic                accept_c;
  logic                forced_c;
  logic                advance_c;
  logic [VALUE_W-1:0]  first_val_c;
  logic [LOC_W-1:0]    next_loc_c;
  logic                lfsr_hi_unused_c;

  assign lfsr_load_c = (state == ST_IDLE) && bus.Start;
  assign lfsr_step_c = (state == ST_SHUFFLE);
  assign lfsr_seed_c = (bus.Seed == '0) ? SEED_ZERO_SUB : bus.Seed;

  lfsr8 #(.RESET_VAL(SEED_ZERO_SUB)) u_lfsr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (lfsr_load_c),
    .load_val (lfsr_seed_c),
    .step     (lfsr_step_c),
    .q        (lfsr_q)
  );

  // Only the low nibble is a draw; the upper bits just carry LFSR state.
  assign lfsr_hi_unused_c = ^lfsr_q[7:4];

  assign draw_c     = lfsr_q[LOC_W-1:0];
  assign accept_c   = (draw_c <= idx);
  assign forced_c   = !accept_c && (retry == RETRY_W'(MAX_RETRY));
  assign advance_c  = accept_c || forced_c;
  assign next_loc_c = loc_q + LOC_W'(1);

  // Final step (idx==1) may swap into slot 0 in the same edge WRITE starts.
  assign first_val_c = (accept_c && (draw_c == '0)) ? deck[idx] : deck[0];

  // Deck storage: reset-free, contents are don't-care until LOAD.
  always_ff @(posedge Clk) begin
    if (state == ST_LOAD) begin
      for (int unsigned k = 0; k < NUM_CARDS; k++) begin
        deck[k] <= VALUE_W'(k >> 1);
      end
    end else if ((state == ST_SHUFFLE) && accept_c) begin
      deck[idx]    <= deck[draw_c];
      deck[draw_c] <= deck[idx];
    end
  end

  // Control FSM with registered port-B outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      loc_q  <= '0;
      data_q <= '0;
      idx    <= '0;
      retry  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          idx   <= LOC_W'(NUM_CARDS - 1);
          retry <= '0;
          state <= ST_SHUFFLE;
        end
        ST_SHUFFLE: begin
          if (advance_c) begin
            retry <= '0;
            idx   <= idx - LOC_W'(1);
            if (idx == LOC_W'(1)) begin
              state  <= ST_WRITE;
              we_q   <= 1'b1;
              loc_q  <= '0;
              data_q <= face_down_card(first_val_c);
            end
          end else begin
            retry <= retry + RETRY_W'(1);
          end
        end
        ST_WRITE: begin
          if (loc_q == LOC_W'(NUM_CARDS - 1)) begin
            state  <= ST_DONE;
            we_q   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            loc_q  <= next_loc_c;
            data_q <= face_down_card(deck[next_loc_c]);
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.WriteEnable = we_q;
  assign bus.DataLoc     = loc_q;
  assign bus.DataOut     = data_q;

endmodule

// File: tb/tb_card_board_loader.sv
// Self-checking bench for card_board_loader against a behavioural
// Fisher-Yates model driven by the same LFSR recurrence.
module tb_card_board_loader;
  import card_pkg::*;

  localparam int MAX_RETRY = 15;
  localparam int LAT_BOUND = 1 + 1 + 15 * (MAX_RETRY + 1) + 16 + 1;

  typedef logic [15:0][3:0] image_t;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  card_board_loader_if bus ();

  card_board_loader dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Reference board: values 0..7 paired, shuffled from i=15 down to 1.
  task automatic model_board(input logic [7:0] seed, output image_t img, output int shuf);
    int deck [16];
    logic [7:0] s;
    int j;
    int tries;
    int tmp;
    bit placed;
    s = (seed == 8'h00) ? 8'h01 : seed;
    shuf = 0;
    for (int k = 0; k < 16; k++) deck[k] = k / 2;
    for (int i = 15; i >= 1; i--) begin
      tries  = 0;
      placed = 0;
      while (!placed) begin
        j = int'(s) % 16;
        s = lfsr_next(s);
        shuf++;
        if (j <= i) begin
          tmp = deck[i]; deck[i] = deck[j]; deck[j] = tmp;
          placed = 1;
        end else if (tries == MAX_RETRY) begin
          placed = 1;
        end else begin
          tries++;
        end
      end
    end
    for (int k = 0; k < 16; k++) img[k] = 4'(deck[k]);
  endtask

  function automatic bit pairs_ok(input image_t img);
    int cnt [16];
    for (int k = 0; k < 16; k++) cnt[k] = 0;
    for (int k = 0; k < 16; k++) cnt[img[k]]++;
    for (int v = 0; v < 8; v++) if (cnt[v] != 2) return 0;
    return 1;
  endfunction

  // Pulses Start and records the port-B stream until the loader returns idle.
  task automatic run_board(input logic [7:0] seed, input bit poke, input logic [7:0] poke_seed,
                           output image_t img, output int we_cnt, output bit order_ok,
                           output bit bits_ok, output int done_cnt, output bit done_after_last,
                           output bit busy_rose, output int cycles, output bit timed_out,
                           output bit stayed_idle);
    int  c;
    int  first_we;
    int  last_we;
    bit  prev_last;
    bit  fin;
    img = '0; we_cnt = 0; order_ok = 1; bits_ok = 1; done_cnt = 0;
    done_after_last = 0; busy_rose = 0; cycles = 0; stayed_idle = 1;
    c = 0; first_we = -1; last_we = -1; prev_last = 0; fin = 0;
    @(negedge Clk);
    bus.Seed  = seed;
    bus.Start = 1'b1;
    while (!fin && c < 400) begin
      @(negedge Clk);
      c++;
      bus.Start = 1'b0;
      if (poke && (c == 3 || (first_we >= 0 && c == first_we + 5))) begin
        bus.Start = 1'b1;
        bus.Seed  = poke_seed;
      end
      if (c == 1) busy_rose = bus.Busy;
      if (bus.WriteEnable) begin
        if (first_we < 0) first_we = c;
        if (we_cnt > 0 && last_we != c - 1) order_ok = 0;
        if (bus.DataLoc != 4'(we_cnt)) order_ok = 0;
        if (bus.DataOut[5:4] !== 2'b01) bits_ok = 0;
        if (we_cnt < 16) img[we_cnt] = bus.DataOut[3:0];
        we_cnt++;
        last_we = c;
      end
      if (bus.Done) begin
        done_cnt++;
        if (cycles == 0) cycles = c;
        done_after_last = prev_last;
      end
      prev_last = bus.WriteEnable && (bus.DataLoc == 4'd15);
      if (done_cnt > 0 && !bus.Busy) fin = 1;
    end
    timed_out = !fin;
    bus.Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (bus.Busy || bus.WriteEnable || bus.Done) stayed_idle = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.WriteEnable); end
    checks++; if (bus.DataLoc !== 4'd0) begin errors++; $display("FAIL reset_loc: got %0d want 0", bus.DataLoc); end
    checks++; if (bus.DataOut !== 6'd0) begin errors++; $display("FAIL reset_data: got %h want 00", bus.DataOut); end
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_full_load(input logic [7:0] seed);
    image_t img, exp_img;
    int we_cnt, done_cnt, cycles, shuf;
    bit order_ok, bits_ok, dal, br, to, idle;
    model_board(seed, exp_img, shuf);
    run_board(seed, 0, 8'h00, img, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    checks++; if (to) begin errors++; $display("FAIL full_timeout: seed %h never finished", seed); end
    checks++; if (br !== 1'b1) begin errors++; $display("FAIL full_busy_rise: got %b want 1", br); end
    checks++; if (we_cnt != 16) begin errors++; $display("FAIL full_we_count: got %0d want 16", we_cnt); end
    checks++; if (!order_ok) begin errors++; $display("FAIL full_order: got out-of-order/gapped writes want 0..15 consecutive"); end
    checks++; if (!bits_ok) begin errors++; $display("FAIL full_flag_bits: got bits5:4 != 01 want 01"); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    checks++; if (!dal) begin errors++; $display("FAIL full_done_timing: got Done not right after loc 15 want 1 cycle after"); end
    checks++; if (!pairs_ok(img)) begin errors++; $display("FAIL full_pairs: got %h want each 0..7 twice", img); end
    checks++; if (img !== exp_img) begin errors++; $display("FAIL full_image: got %h want %h", img, exp_img); end
    checks++; if (cycles != shuf + 18) begin errors++; $display("FAIL full_latency: got %0d want %0d", cycles, shuf + 18); end
    checks++; if (!idle) begin errors++; $display("FAIL full_idle_after: got activity after Done want idle"); end
  endtask

  task automatic test_determinism();
    image_t a, b, m;
    int we_cnt, done_cnt, cycles, shuf;
    bit order_ok, bits_ok, dal, br, to, idle;
    run_board(8'h3C, 0, 8'h00, a, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    run_board(8'h3C, 0, 8'h00, b, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    checks++; if (a !== b) begin errors++; $display("FAIL det_repeat: got %h want %h", b, a); end
    model_board(8'h3C, m, shuf);
    checks++; if (a !== m) begin errors++; $display("FAIL det_3c_model: got %h want %h", a, m); end
    run_board(8'h00, 0, 8'h00, a, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    run_board(8'h01, 0, 8'h00, b, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    checks++; if (a !== b) begin errors++; $display("FAIL det_seed_zero: got %h want %h", a, b); end
    model_board(8'h01, m, shuf);
    checks++; if (b !== m) begin errors++; $display("FAIL det_01_model: got %h want %h", b, m); end
    run_board(8'h3C, 0, 8'h00, a, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    run_board(8'hC3, 0, 8'h00, b, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    checks++; if (a === b) begin errors++; $display("FAIL det_differ: got %h for both seeds want different images", a); end
    model_board(8'hC3, m, shuf);
    checks++; if (b !== m) begin errors++; $display("FAIL det_c3_model: got %h want %h", b, m); end
  endtask

  task automatic test_start_while_busy();
    image_t img, exp_img;
    int we_cnt, done_cnt, cycles, shuf;
    bit order_ok, bits_ok, dal, br, to, idle;
    model_board(8'h77, exp_img, shuf);
    run_board(8'h77, 1, 8'h12, img, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    checks++; if (img !== exp_img) begin errors++; $display("FAIL busy_image: got %h want %h", img, exp_img); end
    checks++; if (cycles != shuf + 18) begin errors++; $display("FAIL busy_latency: got %0d want %0d", cycles, shuf + 18); end
    checks++; if (done_cnt != 1 || we_cnt != 16) begin errors++; $display("FAIL busy_counts: got done=%0d we=%0d want 1/16", done_cnt, we_cnt); end
    checks++; if (!idle) begin errors++; $display("FAIL busy_no_queue: got restart after Done want idle"); end
  endtask

  task automatic test_reset_mid_write();
    image_t img, exp_img;
    int we_cnt, done_cnt, cycles, shuf, c;
    bit order_ok, bits_ok, dal, br, to, idle, hit;
    hit = 0; c = 0;
    @(negedge Clk);
    bus.Seed = 8'hE1; bus.Start = 1'b1;
    while (!hit && c < 400) begin
      @(negedge Clk);
      c++;
      bus.Start = 1'b0;
      if (bus.WriteEnable && bus.DataLoc == 4'd7) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_reach_k7: got no write at loc 7 within 400 cycles want one"); end
    #1 Reset = 1'b0;
    #1;
    checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %b want 0", bus.WriteEnable); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", bus.Busy); end
    checks++; if (bus.DataLoc !== 4'd0 || bus.DataOut !== 6'd0 || bus.Done !== 1'b0)
      begin errors++; $display("FAIL rst_async_bus: got loc=%0d data=%h done=%b want 0/00/0", bus.DataLoc, bus.DataOut, bus.Done); end
    @(negedge Clk);
    Reset = 1'b1;
    model_board(8'h5A, exp_img, shuf);
    run_board(8'h5A, 0, 8'h00, img, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
    checks++; if (we_cnt != 16 || !order_ok) begin errors++; $display("FAIL rst_rewrite: got %0d writes order_ok=%b want 16/1", we_cnt, order_ok); end
    checks++; if (img !== exp_img) begin errors++; $display("FAIL rst_image: got %h want %h", img, exp_img); end
  endtask

  task automatic test_all_seeds();
    image_t img, exp_img;
    int we_cnt, done_cnt, cycles, shuf;
    bit order_ok, bits_ok, dal, br, to, idle;
    for (int s = 0; s < 256; s++) begin
      model_board(8'(s), exp_img, shuf);
      run_board(8'(s), 0, 8'h00, img, we_cnt, order_ok, bits_ok, done_cnt, dal, br, cycles, to, idle);
      checks++; if (to || cycles > LAT_BOUND) begin errors++; $display("FAIL seed_latency[%0d]: got %0d want <= %0d", s, cycles, LAT_BOUND); end
      checks++; if (!pairs_ok(img) || !bits_ok) begin errors++; $display("FAIL seed_pairs[%0d]: got %h want each 0..7 twice, flags 01", s, img); end
      checks++; if (img !== exp_img) begin errors++; $display("FAIL seed_image[%0d]: got %h want %h", s, img, exp_img); end
      checks++; if (we_cnt != 16 || !order_ok || done_cnt != 1) begin errors++; $display("FAIL seed_stream[%0d]: got we=%0d order=%b done=%0d want 16/1/1", s, we_cnt, order_ok, done_cnt); end
    end
  endtask

  initial begin
    Reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Seed  = 8'h00;
    test_reset();
    test_full_load(8'hA5);
    test_determinism();
    test_start_while_busy();
    test_reset_mid_write();
    test_all_seeds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
